// File: rtl/rah_pkg.sv
// Shared definitions for the RAH TX encoder: sync byte, header field layout,
// FSM state encoding and a header-building helper.
package rah_pkg;

    localparam logic [7:0] RAH_SYNC = 8'hA5;

    localparam int HDR_W        = 32;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 16;
    localparam int HDR_APP_LSB  = 16;
    localparam int HDR_APP_W    = 8;
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_SYNC_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GAP
    } rah_state_e;

    function automatic logic [HDR_W-1:0] rah_header(input logic [HDR_LEN_W-1:0] len,
                                                    input logic [HDR_APP_W-1:0] app);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_LEN_LSB  +: HDR_LEN_W]  = len;
        h[HDR_APP_LSB  +: HDR_APP_W]  = app;
        h[HDR_SYNC_LSB +: HDR_SYNC_W] = RAH_SYNC;
        return h;
    endfunction

endpackage

// File: rtl/rah_tx_fifo.sv
// Per-app synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write strobe/data; ignored when full
//   rd_en           pop the head word; ignored when empty
//   rd_data         current head word (valid whenever !empty)
//   count           words stored, $clog2(FIFO_DEPTH)+1 bits
//   empty, full, almost_full (count >= FIFO_DEPTH-4)
// FIFO_DEPTH must be a power of two (>= 8) so pointers wrap naturally.
module rah_tx_fifo #(
    parameter int DATA_WIDTH = 48,
    parameter int FIFO_DEPTH = 512,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign almost_full = (count >= CW'(FIFO_DEPTH - 4));
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rah_encoder.sv
// RAH TX encoder: buffers per-app words, round-robin arbitrates among the
// app FIFOs and frames each burst as one header word plus LEN payload beats
// on a valid/ready stream toward the MIPI TX lane.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_data           per-app write strobes / packed write words
//   data_queue_full          per-app FIFO full
//   data_queue_almost_full   per-app FIFO count >= FIFO_DEPTH-4
//   error                    per-app sticky overflow (write while full)
//   mipi_data, mipi_tx_valid registered TX word and valid
//   mipi_tx_ready            lane accepts the word this cycle
//   end_of_packet            registered: high for the one cycle that follows
//                            the accepted last payload beat
//
// state   | meaning
// IDLE    | scan FIFOs from rr_ptr, grant first non-empty app, snapshot LEN
// HEADER  | header word presented, wait for accept
// PAYLOAD | payload beats presented, beat_cnt = beats still to be accepted
// GAP     | one idle cycle with valid low between packets
module rah_encoder
    import rah_pkg::*;
#(
    parameter int TOTAL_APPS  = 2,
    parameter int DATA_WIDTH  = 48,
    parameter int FIFO_DEPTH  = 512,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [TOTAL_APPS-1:0]            wr_en,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] wr_data,
    output logic [TOTAL_APPS-1:0]            data_queue_full,
    output logic [TOTAL_APPS-1:0]            data_queue_almost_full,
    output logic [TOTAL_APPS-1:0]            error,
    output logic [DATA_WIDTH-1:0]            mipi_data,
    output logic                             mipi_tx_valid,
    input  logic                             mipi_tx_ready,
    output logic                             end_of_packet
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1;

    logic [DATA_WIDTH-1:0] fifo_head  [TOTAL_APPS];
    logic [CW-1:0]         fifo_count [TOTAL_APPS];
    logic [TOTAL_APPS-1:0] fifo_empty;
    logic [TOTAL_APPS-1:0] rd_en;

    rah_state_e            state, state_n;
    logic [AW-1:0]         app_id, app_id_n;
    logic [AW-1:0]         rr_ptr, rr_ptr_n;
    logic [15:0]           beat_cnt, beat_cnt_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  eop_n;

    logic                  hit;
    logic [AW-1:0]         hit_idx;
    logic [15:0]           hit_len;
    int                    scan_idx;
    logic                  accept;

    for (genvar g = 0; g < TOTAL_APPS; g++) begin : g_fifo
        rah_tx_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH),
            .CW        (CW)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[g]),
            .wr_data    (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en      (rd_en[g]),
            .rd_data    (fifo_head[g]),
            .count      (fifo_count[g]),
            .empty      (fifo_empty[g]),
            .full       (data_queue_full[g]),
            .almost_full(data_queue_almost_full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) error <= '0;
        else     error <= error | (wr_en & data_queue_full);
    end

    assign accept = mipi_tx_valid && mipi_tx_ready;

    // Round-robin scan: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = 0;
        for (int i = 0; i < TOTAL_APPS; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= TOTAL_APPS) scan_idx = scan_idx - TOTAL_APPS;
            if (!hit && !fifo_empty[scan_idx]) begin
                hit     = 1'b1;
                hit_idx = AW'(scan_idx);
            end
        end
        if (32'(fifo_count[hit_idx]) > MAX_PAYLOAD) hit_len = 16'(MAX_PAYLOAD);
        else                                        hit_len = 16'(fifo_count[hit_idx]);
    end

    // The output register is reloaded from the FIFO head at the same edge the
    // previous beat is accepted, and the FIFO pops at that edge, so the next
    // head is already waiting and beats stream back-to-back.
    always_comb begin
        state_n    = state;
        app_id_n   = app_id;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        data_n     = mipi_data;
        valid_n    = mipi_tx_valid;
        eop_n      = 1'b0;
        rd_en      = '0;
        case (state)
            ST_IDLE: begin
                valid_n = 1'b0;
                if (hit) begin
                    app_id_n   = hit_idx;
                    rr_ptr_n   = (hit_idx == AW'(TOTAL_APPS - 1)) ? '0 : hit_idx + AW'(1);
                    beat_cnt_n = hit_len;
                    data_n     = DATA_WIDTH'(rah_header(hit_len, 8'(hit_idx)));
                    valid_n    = 1'b1;
                    state_n    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    data_n        = fifo_head[app_id];
                    rd_en[app_id] = 1'b1;
                    state_n       = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    beat_cnt_n = beat_cnt - 16'd1;
                    if (beat_cnt == 16'd1) begin
                        valid_n = 1'b0;
                        eop_n   = 1'b1;
                        state_n = ST_GAP;
                    end else begin
                        data_n        = fifo_head[app_id];
                        rd_en[app_id] = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                valid_n = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                valid_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            app_id        <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            mipi_data     <= '0;
            mipi_tx_valid <= 1'b0;
            end_of_packet <= 1'b0;
        end else begin
            state         <= state_n;
            app_id        <= app_id_n;
            rr_ptr        <= rr_ptr_n;
            beat_cnt      <= beat_cnt_n;
            mipi_data     <= data_n;
            mipi_tx_valid <= valid_n;
            end_of_packet <= eop_n;
        end
    end

endmodule

// File: tb/tb_rah_encoder.sv
// Self-checking bench for rah_encoder: expected payload words per app and
// expected header words are queued as stimulus is driven; a negedge monitor
// pops and compares them as beats are accepted on the lane.
module tb_rah_encoder;

    localparam int TA = 2;
    localparam int DW = 48;
    localparam int FD = 512;
    localparam int MP = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [TA-1:0]     wr_en = '0;
    logic [TA*DW-1:0]  wr_data = '0;
    logic [TA-1:0]     data_queue_full;
    logic [TA-1:0]     data_queue_almost_full;
    logic [TA-1:0]     error;
    logic [DW-1:0]     mipi_data;
    logic              mipi_tx_valid;
    logic              mipi_tx_ready = 1'b0;
    logic              end_of_packet;

    rah_encoder #(
        .TOTAL_APPS (TA),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .MAX_PAYLOAD(MP)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .wr_en                 (wr_en),
        .wr_data               (wr_data),
        .data_queue_full       (data_queue_full),
        .data_queue_almost_full(data_queue_almost_full),
        .error                 (error),
        .mipi_data             (mipi_data),
        .mipi_tx_valid         (mipi_tx_valid),
        .mipi_tx_ready         (mipi_tx_ready),
        .end_of_packet         (end_of_packet)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [31:0]   hdr_q [$];

    int            ready_mode = 0;   // 0 low, 1 high, 2 toggle every cycle

    // monitor state
    bit            in_pkt = 0;
    int            cur_app = 0;
    int            beats_left = 0;
    int            pay_seen = 0;
    bit            eop_due = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [31:0]   m_hdr;
    logic [DW-1:0] m_dat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input int app, input int len);
        return {8'hA5, 8'(app), 16'(len)};
    endfunction

    function automatic logic [DW-1:0] word(input int tst, input int app, input int n);
        return {8'(tst), 8'(app), 32'(n)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_pkt     = 0;
            beats_left = 0;
            pay_seen   = 0;
            eop_due    = 0;
            prev_stall = 0;
        end else begin
            check_eq("eop", 64'(end_of_packet), 64'(eop_due));
            if (eop_due) check_eq("gap_valid", 64'(mipi_tx_valid), 64'd0);
            if (prev_stall) begin
                check_eq("stall_valid", 64'(mipi_tx_valid), 64'd1);
                check_eq("stall_data", 64'(mipi_data), 64'(prev_data));
            end
            eop_due = 0;
            if (mipi_tx_valid && mipi_tx_ready) begin
                if (!in_pkt) begin
                    if (hdr_q.size() == 0) begin
                        check_eq("unexpected_hdr", 64'(mipi_data), 64'd0);
                    end else begin
                        m_hdr = hdr_q.pop_front();
                        check_eq("hdr", 64'(mipi_data), 64'(m_hdr));
                    end
                    cur_app    = int'(mipi_data[23:16]);
                    beats_left = int'(mipi_data[15:0]);
                    pay_seen   = 0;
                    in_pkt     = 1;
                end else begin
                    if (cur_app == 0 && q0.size() != 0) begin
                        m_dat = q0.pop_front();
                        check_eq("payload0", 64'(mipi_data), 64'(m_dat));
                    end else if (cur_app == 1 && q1.size() != 0) begin
                        m_dat = q1.pop_front();
                        check_eq("payload1", 64'(mipi_data), 64'(m_dat));
                    end else begin
                        check_eq("payload_underflow", 64'(mipi_data), 64'hDEAD);
                    end
                    pay_seen++;
                    beats_left--;
                    if (beats_left <= 0) begin
                        in_pkt  = 0;
                        eop_due = 1;
                    end
                end
            end
            prev_stall = mipi_tx_valid && !mipi_tx_ready;
            prev_data  = mipi_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 2) mipi_tx_ready = ~mipi_tx_ready;
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        hdr_q.delete();
    endtask

    task automatic do_reset();
        ready_mode    = 0;
        mipi_tx_ready = 1'b0;
        wr_en         = '0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        flush();
    endtask

    task automatic wr1(input int app, input logic [DW-1:0] d, input bit expect_it);
        wr_en              = '0;
        wr_en[app]         = 1'b1;
        wr_data[app*DW +: DW] = d;
        if (expect_it) begin
            if (app == 0) q0.push_back(d);
            else          q1.push_back(d);
        end
        tick();
        wr_en = '0;
    endtask

    task automatic wr2(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        wr_en = 2'b11;
        wr_data = {d1, d0};
        q0.push_back(d0);
        q1.push_back(d1);
        tick();
        wr_en = '0;
    endtask

    task automatic release_ready(input int mode);
        ready_mode    = mode;
        mipi_tx_ready = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hdr_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
                !in_pkt && !mipi_tx_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) check_eq({tag, "_drain_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // reset state
        do_reset();
        check_eq("rst_valid", 64'(mipi_tx_valid), 64'd0);
        check_eq("rst_data",  64'(mipi_data), 64'd0);
        check_eq("rst_eop",   64'(end_of_packet), 64'd0);
        check_eq("rst_full",  64'(data_queue_full), 64'd0);
        check_eq("rst_af",    64'(data_queue_almost_full), 64'd0);
        check_eq("rst_err",   64'(error), 64'd0);

        // 1: latency from a single write, then app0 3-word packet
        hdr_q.push_back(hdr(1, 1));
        hdr_q.push_back(hdr(0, 3));
        wr1(1, word(1, 1, 0), 1);          // written in cycle N, now in N+1
        check_eq("lat_n1_valid", 64'(mipi_tx_valid), 64'd0);
        wr1(0, 48'd1, 1);                  // now in N+2
        check_eq("lat_n2_valid", 64'(mipi_tx_valid), 64'd1);
        check_eq("lat_n2_hdr", 64'(mipi_data), 64'(hdr(1, 1)));
        wr1(0, 48'd2, 1);
        wr1(0, 48'd3, 1);
        release_ready(1);
        wait_drain("t1");

        // 2: 100 words on app0 split 64 + 36
        do_reset();
        hdr_q.push_back(hdr(1, 1));
        hdr_q.push_back(hdr(0, 64));
        hdr_q.push_back(hdr(0, 36));
        wr1(1, word(2, 1, 0), 1);
        for (int i = 0; i < 100; i++) wr1(0, word(2, 0, i), 1);
        release_ready(1);
        wait_drain("t2");

        // 3: both apps loaded -> app0, app1, app0
        do_reset();
        hdr_q.push_back(hdr(0, 1));
        hdr_q.push_back(hdr(1, 3));
        hdr_q.push_back(hdr(0, 3));
        wr1(0, word(3, 0, 100), 1);
        for (int i = 0; i < 3; i++) wr2(word(3, 0, i), word(3, 1, i));
        release_ready(1);
        wait_drain("t3");

        // 4: ready toggling during payload
        do_reset();
        hdr_q.push_back(hdr(1, 1));
        hdr_q.push_back(hdr(0, 5));
        wr1(1, word(4, 1, 0), 1);
        for (int i = 0; i < 5; i++) wr1(0, word(4, 0, i), 1);
        release_ready(2);
        wait_drain("t4");

        // 5: overflow app1
        do_reset();
        hdr_q.push_back(hdr(0, 1));
        for (int i = 0; i < FD / MP; i++) hdr_q.push_back(hdr(1, MP));
        wr1(0, word(5, 0, 0), 1);
        for (int i = 0; i < FD; i++) begin
            wr1(1, word(5, 1, i), 1);
            if (i == FD - 6) check_eq("af_below", 64'(data_queue_almost_full[1]), 64'd0);
            if (i == FD - 5) check_eq("af_at",    64'(data_queue_almost_full[1]), 64'd1);
            if (i == FD - 2) check_eq("full_below", 64'(data_queue_full[1]), 64'd0);
        end
        check_eq("full_at", 64'(data_queue_full), 64'b10);
        check_eq("err_before", 64'(error), 64'd0);
        wr1(1, 48'hBAD0_BAD0_BAD0, 0);
        check_eq("err_after", 64'(error), 64'b10);
        check_eq("full_after", 64'(data_queue_full[1]), 64'd1);
        release_ready(1);
        wait_drain("t5");
        check_eq("err_sticky", 64'(error), 64'b10);
        check_eq("full_drained", 64'(data_queue_full), 64'd0);

        // 6: reset mid-payload, then a clean packet
        do_reset();
        check_eq("err_cleared", 64'(error), 64'd0);
        hdr_q.push_back(hdr(1, 1));
        hdr_q.push_back(hdr(0, 10));
        wr1(1, word(6, 1, 0), 1);
        for (int i = 0; i < 10; i++) wr1(0, word(6, 0, i), 1);
        release_ready(1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (in_pkt && cur_app == 0 && pay_seen >= 3) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) check_eq("t6_midpkt_timeout", 64'd0, 64'd1);
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", 64'(mipi_tx_valid), 64'd0);
        check_eq("midrst_eop",   64'(end_of_packet), 64'd0);
        check_eq("midrst_flags", 64'({data_queue_full, data_queue_almost_full, error}), 64'd0);
        rst = 1'b0;
        flush();
        ready_mode    = 1;
        mipi_tx_ready = 1'b1;
        hdr_q.push_back(hdr(0, 1));
        wr1(0, 48'h00AB_CDEF_0123, 1);
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
